// File: rtl/rr_mux_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : rr_mux_pipe_pkg                                             |
// | Description: Shared mode encoding and width helper for the round-robin   |
// |              / fixed-select pipelined multiplexer.                       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package rr_mux_pipe_pkg;

  // Mode encoding of the mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, never less than 1 so a select bus always has a bit
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage : rr_mux_pipe_pkg
`default_nettype wire

// File: rtl/rr_mux_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : rr_mux_pipe_if                                              |
// | Description: Producer/consumer bundle of the pipelined mux.              |
// |   mode      : 0 = fixed select, 1 = round-robin                          |
// |   sel       : source index in fixed mode                                 |
// |   in_data   : NUM_IN packed channels, channel i at [i*WIDTH +: WIDTH]    |
// |   in_valid  : per-channel valid        in_ready : per-channel ready      |
// |   out_data  : registered beat          out_sel  : channel of that beat   |
// |   out_valid : beat held                out_ready: consumer accepts       |
// |   modport slave = mux side, modport master = environment side           |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface rr_mux_pipe_if
  import rr_mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8
) ();
  localparam int SEL_W = clog2(NUM_IN);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
endinterface : rr_mux_pipe_if
`default_nettype wire

// File: rtl/rr_mux_pipe_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : rr_pick                                                     |
// | Description: Combinational rotate-priority search. Returns the first     |
// |              set request scanning ptr, ptr+1, ... modulo NUM_IN.         |
// |   req   : request vector          ptr : starting index                   |
// |   found : any request set         idx : index of the winner              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module rr_pick
  import rr_mux_pipe_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  wire logic [NUM_IN-1:0] req,
  input  wire logic [SEL_W-1:0]  ptr,
  output logic                   found,
  output logic [SEL_W-1:0]       idx
);

  int w_start;
  int w_pos;

  always_comb begin
    found   = 1'b0;
    idx     = '0;
    // A pointer outside the channel range cannot occur in normal use;
    // fall back to channel 0 so the search stays well defined.
    w_start = (int'(ptr) < NUM_IN) ? int'(ptr) : 0;
    w_pos   = 0;
    for (int off = 0; off < NUM_IN; off++) begin
      w_pos = w_start + off;
      if (w_pos >= NUM_IN) begin
        w_pos = w_pos - NUM_IN;
      end
      if (!found && req[w_pos]) begin
        found = 1'b1;
        idx   = SEL_W'(w_pos);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_mux_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : rr_mux_pipe                                                 |
// | Description: N-to-1 data mux with one registered output stage and        |
// |              valid/ready handshakes on both sides. Source chosen by an   |
// |              external select (fixed mode) or a round-robin arbiter.      |
// |   clk : rising-edge clock      rst : synchronous active-high reset       |
// |   bus : rr_mux_pipe_if.slave (mode, sel, in_*, out_*)                    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module rr_mux_pipe
  import rr_mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  rr_mux_pipe_if.slave bus
);
  localparam int SEL_W = clog2(NUM_IN);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_sel_ok;
  logic             w_found;
  logic [SEL_W-1:0] w_grant;
  logic             w_load_en;
  logic             w_in_xfer;
  logic [WIDTH-1:0] w_grant_data;
  logic [NUM_IN-1:0] w_in_ready;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_q),
    .found (w_rr_found),
    .idx   (w_rr_idx)
  );

  // Grant selection; depends on in_valid but only feeds in_ready and the
  // register inputs, never out_* directly.
  always_comb begin
    w_sel_ok = (int'(bus.sel) < NUM_IN);
    if (bus.mode == MODE_RR) begin
      w_found = w_rr_found;
      w_grant = w_rr_idx;
    end else begin
      // Out-of-range selects are never granted
      w_found = w_sel_ok && bus.in_valid[bus.sel];
      w_grant = bus.sel;
    end
  end

  // The single output stage can take a beat when empty or draining this edge
  assign w_load_en = !out_valid_q || bus.out_ready;
  assign w_in_xfer = !rst && w_load_en && w_found;

  always_comb begin
    w_in_ready   = '0;
    w_grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_in_ready[i] = w_in_xfer;
        w_grant_data  = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (w_in_xfer) begin
      // A new beat replaces a draining one in the same edge
      out_data_d  = w_grant_data;
      out_sel_d   = w_grant;
      out_valid_d = 1'b1;
      if (bus.mode == MODE_RR) begin
        rr_ptr_d = (int'(w_grant) == NUM_IN - 1) ? '0 : w_grant + 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      // Drained with nothing behind it; data/sel left as they were
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule : rr_mux_pipe
`default_nettype wire

// File: tb/tb_rr_mux_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_rr_mux_pipe                                              |
// | Description: Self-checking bench for rr_mux_pipe: vector table, corner   |
// |              sequences and randomized traffic against a queue-free       |
// |              behavioural model.                                          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_rr_mux_pipe;
  import rr_mux_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  rr_mux_pipe_if #(.WIDTH(32), .NUM_IN(8)) bus8 ();
  rr_mux_pipe_if #(.WIDTH(32), .NUM_IN(6)) bus6 ();

  rr_mux_pipe #(.WIDTH(32), .NUM_IN(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  rr_mux_pipe #(.WIDTH(32), .NUM_IN(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  logic [31:0] ch [8];

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       ordy;
    logic [7:0] exp_ready;
    logic       exp_valid;
    logic [2:0] exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [28];

  // model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pack8();
    for (int i = 0; i < 8; i++) bus8.in_data[i*32 +: 32] = ch[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule straight from the behavioural description
  task automatic model_grant(input logic mode, input int sel, input logic [7:0] v,
                             input int ptr, output logic found, output int idx);
    found = 1'b0;
    idx   = 0;
    if (mode == MODE_FIXED) begin
      if (sel < 8 && v[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (!found && v[(ptr + k) % 8]) begin
          found = 1'b1;
          idx   = (ptr + k) % 8;
        end
      end
    end
  endtask

  initial begin
    logic       f;
    int         g;
    logic       ld;
    logic       xfer;
    logic [7:0] er;

    // ---------------- vector table ----------------
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{MODE_FIXED, 3'(i), 8'hFF, 1'b1, 8'(1 << i), 1'b1, 3'(i), 32'(i)};
    end
    for (int i = 0; i < 16; i++) begin
      vecs[8+i] = '{MODE_RR, 3'd0, 8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b1, 3'(i % 8), 32'(i % 8)};
    end
    for (int i = 0; i < 4; i++) begin
      int e;
      e = (i % 2 == 0) ? 1 : 7;
      vecs[24+i] = '{MODE_RR, 3'd0, 8'b1000_0010, 1'b1, 8'(1 << e), 1'b1, 3'(e), 32'(e)};
    end

    // ---------------- reset ----------------
    for (int i = 0; i < 8; i++) ch[i] = 32'(i);
    pack8();
    rst            = 1'b1;
    bus8.mode      = MODE_FIXED;
    bus8.sel       = '0;
    bus8.in_valid  = 8'hFF;
    bus8.out_ready = 1'b1;
    bus6.mode      = MODE_FIXED;
    bus6.sel       = '0;
    bus6.in_valid  = '0;
    bus6.in_data   = '0;
    bus6.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus8.out_data),  64'd0);
    chk("rst_out_sel",   64'(bus8.out_sel),   64'd0);
    chk("rst_in_ready",  64'(bus8.in_ready),  64'd0);
    rst = 1'b0;

    // ---------------- table: fixed sweep, RR fairness, sparse wrap ----------------
    for (int n = 0; n < 28; n++) begin
      bus8.mode      = vecs[n].mode;
      bus8.sel       = vecs[n].sel;
      bus8.in_valid  = vecs[n].valid;
      bus8.out_ready = vecs[n].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", n), 64'(bus8.in_ready), 64'(vecs[n].exp_ready));
      tick();
      chk($sformatf("tbl%0d_out_valid", n), 64'(bus8.out_valid), 64'(vecs[n].exp_valid));
      chk($sformatf("tbl%0d_out_sel", n),   64'(bus8.out_sel),   64'(vecs[n].exp_sel));
      chk($sformatf("tbl%0d_out_data", n),  64'(bus8.out_data),  64'(vecs[n].exp_data));
    end
    chk("rr_ptr_after_wrap", 64'(dut8.rr_ptr_q), 64'd0);

    // ---------------- back-pressure ----------------
    ch[3] = 32'hDEAD_BEEF;
    pack8();
    bus8.mode     = MODE_FIXED;
    bus8.sel      = 3'd3;
    bus8.in_valid = 8'hFF;
    tick();
    chk("bp_load_data", 64'(bus8.out_data), 64'hDEAD_BEEF);
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus8.sel = 3'(i + 1);
      ch[3]    = $urandom;
      pack8();
      bus8.mode = logic'(i % 2);
      #1;
      chk("bp_in_ready", 64'(bus8.in_ready), 64'd0);
      tick();
      chk("bp_out_valid", 64'(bus8.out_valid), 64'd1);
      chk("bp_out_data",  64'(bus8.out_data),  64'hDEAD_BEEF);
      chk("bp_out_sel",   64'(bus8.out_sel),   64'd3);
    end
    ch[3] = 32'd3;
    pack8();
    bus8.mode      = MODE_FIXED;
    bus8.sel       = 3'd5;
    bus8.out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 64'(bus8.in_ready), 64'h20);
    tick();
    chk("bp_resume_valid", 64'(bus8.out_valid), 64'd1);
    chk("bp_resume_sel",   64'(bus8.out_sel),   64'd5);
    chk("bp_resume_data",  64'(bus8.out_data),  64'd5);

    // ---------------- invalid select on a 6-channel instance ----------------
    bus8.in_valid = '0;
    for (int i = 0; i < 6; i++) bus6.in_data[i*32 +: 32] = 32'(i);
    bus6.in_valid = 6'h3F;
    bus6.sel      = 3'd2;
    tick();
    chk("n6_load_valid", 64'(bus6.out_valid), 64'd1);
    chk("n6_load_sel",   64'(bus6.out_sel),   64'd2);
    bus6.sel = 3'd7;
    #1;
    chk("n6_badsel_ready", 64'(bus6.in_ready), 64'd0);
    tick();
    chk("n6_drain_valid", 64'(bus6.out_valid), 64'd0);
    chk("n6_hold_sel",    64'(bus6.out_sel),   64'd2);
    chk("n6_hold_data",   64'(bus6.out_data),  64'd2);
    chk("n8_idle_drain",  64'(bus8.out_valid), 64'd0);

    // ---------------- reset with a held beat ----------------
    bus8.in_valid  = 8'hFF;
    bus8.sel       = 3'd6;
    bus8.mode      = MODE_RR;
    tick();
    chk("mid_load_valid", 64'(bus8.out_valid), 64'd1);
    bus8.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(bus8.in_ready), 64'd0);
    tick();
    chk("mid_rst_valid", 64'(bus8.out_valid), 64'd0);
    chk("mid_rst_data",  64'(bus8.out_data),  64'd0);
    chk("mid_rst_ptr",   64'(dut8.rr_ptr_q),  64'd0);
    rst = 1'b0;

    // ---------------- randomized traffic vs model ----------------
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
    for (int c = 0; c < 400; c++) begin
      bus8.mode      = logic'($urandom_range(0, 1));
      bus8.sel       = 3'($urandom_range(0, 7));
      bus8.in_valid  = 8'($urandom & $urandom);
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) ch[i] = $urandom;
      pack8();
      model_grant(bus8.mode, int'(bus8.sel), bus8.in_valid, m_ptr, f, g);
      ld   = !m_valid || bus8.out_ready;
      xfer = ld && f;
      er   = xfer ? 8'(1 << g) : 8'd0;
      #1;
      chk("rnd_in_ready", 64'(bus8.in_ready), 64'(er));
      if (xfer) begin
        m_valid = 1'b1;
        m_data  = ch[g];
        m_sel   = g;
        if (bus8.mode == MODE_RR) m_ptr = (g + 1) % 8;
      end else if (m_valid && bus8.out_ready) begin
        m_valid = 1'b0;
      end
      tick();
      chk("rnd_out_valid", 64'(bus8.out_valid), 64'(m_valid));
      chk("rnd_out_sel",   64'(bus8.out_sel),   64'(m_sel));
      chk("rnd_out_data",  64'(bus8.out_data),  64'(m_data));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_mux_pipe
`default_nettype wire
